cpu_call_stack: RTL

//  Hardware return-address stack for the one-cycle CPU. It replaces the single link register.

---
 rtl/cpu_call_stack_pkg.sv | 13 +
 rtl/cpu_stack_ram.sv | 25 ++
 rtl/cpu_call_stack.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_call_stack_pkg.sv
// Shared definitions for the return-address stack: FSM states and fault codes.
package cpu_call_stack_pkg;

    typedef enum logic {
        STK_NORMAL = 1'b0,
        STK_FAULT  = 1'b1
    } stk_state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

endpackage

// File: rtl/cpu_stack_ram.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.
module cpu_stack_ram #(
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [IW-1:0]     WADDR,
    input  logic [AWIDTH-1:0] WDATA,
    input  logic [IW-1:0]     RADDR,
    output logic [AWIDTH-1:0] RDATA
);

    logic [AWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
    end

    assign RDATA = mem[RADDR];

endmodule

// File: rtl/cpu_call_stack.sv
// Hardware return-address stack with overflow/underflow fault trap; replaces the link register.
module cpu_call_stack
    import cpu_call_stack_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int CWIDTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [AWIDTH-1:0] PUSH_ADDR,
    output logic [AWIDTH-1:0] TOP_ADDR,
    output logic              EMPTY,
    output logic              FULL,
    output logic [CWIDTH-1:0] COUNT,
    output logic              FAULT,
    output logic [1:0]        FAULT_CODE
);

    localparam int IW = $clog2(DEPTH);

    stk_state_t        state, state_n;
    logic [CWIDTH-1:0] count, count_n;
    logic [1:0]        code, code_n;
    logic              we;
    logic [IW-1:0]     waddr;
    logic [IW-1:0]     raddr;
    logic [AWIDTH-1:0] rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= STK_NORMAL;
            count <= '0;
            code  <= FC_NONE;
        end else begin
            state <= state_n;
            count <= count_n;
            code  <= code_n;
        end
    end

    assign EMPTY = (count == '0);
    assign FULL  = (count == CWIDTH'(DEPTH));
    // Top entry sits one below COUNT; at FULL the low bits wrap to the last slot.
    assign raddr = count[IW-1:0] - IW'(1);

    always_comb begin
        state_n = state;
        count_n = count;
        code_n  = code;
        we      = 1'b0;
        waddr   = count[IW-1:0];
        if (CLR) begin
            state_n = STK_NORMAL;
            count_n = '0;
            code_n  = FC_NONE;
        end else if (state == STK_NORMAL) begin
            unique case ({PUSH, POP})
                2'b10: begin
                    if (FULL) begin
                        state_n = STK_FAULT;
                        code_n  = FC_OVF;
                    end else begin
                        we      = 1'b1;
                        count_n = count + CWIDTH'(1);
                    end
                end
                2'b01: begin
                    if (EMPTY) begin
                        state_n = STK_FAULT;
                        code_n  = FC_UNF;
                    end else begin
                        count_n = count - CWIDTH'(1);
                    end
                end
                2'b11: begin
                    // Simultaneous call/return replaces the top entry in place.
                    if (EMPTY) begin
                        state_n = STK_FAULT;
                        code_n  = FC_UNF;
                    end else begin
                        we    = 1'b1;
                        waddr = raddr;
                    end
                end
                default: ;
            endcase
        end
    end

    cpu_stack_ram #(
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_ram (
        .CLK   (CLK),
        .WE    (we),
        .WADDR (waddr),
        .WDATA (PUSH_ADDR),
        .RADDR (raddr),
        .RDATA (rdata)
    );

    assign TOP_ADDR   = EMPTY ? '0 : rdata;
    assign COUNT      = count;
    assign FAULT      = (state == STK_FAULT);
    assign FAULT_CODE = code;

endmodule
